// File: rtl/layer_pkg.sv
// layer_pkg: shared state encoding, address widths and constants for the layer scheduler.
package layer_pkg;
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_DONE} state_t;
    localparam int AW = 7;
    localparam int WW = 14;
    localparam int MAC_PIPE_DEPTH = 6;
    localparam logic [AW-1:0] IDLE_ADDR = 7'd127;
endpackage

// File: rtl/issue_counter.sv
// issue_counter: nested output/input counter holding the next (o, i) triple to issue,
// plus a linear weight index that increments alongside it instead of multiplying.
module issue_counter
    import layer_pkg::*;
#(
    parameter int N_IN  = 16,
    parameter int N_OUT = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_en,
    input  logic          i_clear,
    output logic [AW-1:0] o_i,
    output logic [AW-1:0] o_o,
    output logic [WW-1:0] o_widx,
    output logic          o_last
);
    logic w_i_wrap;

    assign w_i_wrap = o_i == AW'(N_IN - 1);
    assign o_last   = w_i_wrap && o_o == AW'(N_OUT - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_i    <= '0;
            o_o    <= '0;
            o_widx <= '0;
        end else if (i_clear) begin
            o_i    <= '0;
            o_o    <= '0;
            o_widx <= '0;
        end else if (i_en) begin
            o_widx <= o_widx + WW'(1);
            o_i    <= w_i_wrap ? '0 : o_i + AW'(1);
            o_o    <= w_i_wrap ? o_o + AW'(1) : o_o;
        end
    end
endmodule

// File: rtl/layer_sched.sv
// layer_sched: clears the psum entries, issues every (input, weight, output) triple of a
// fully connected layer into the MAC with stall bubbles, drains the pipeline and pulses done.
module layer_sched
    import layer_pkg::*;
#(
    parameter int          N_IN       = 16,
    parameter int          N_OUT      = 10,
    parameter int          PIPE_DEPTH = MAC_PIPE_DEPTH,
    parameter logic [AW-1:0] IDLE_ADDR = layer_pkg::IDLE_ADDR
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          go,
    input  logic          stall,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] in_rd_addr,
    output logic [WW-1:0] wt_rd_addr,
    output logic [AW-1:0] mac_addr,
    output logic          mac_start,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr,
    output logic          rf_sel
);
    state_t        r_state;
    logic [7:0]    r_drain;
    logic          r_last_issued;
    logic          w_start;
    logic          w_launch;
    logic          w_en;
    logic          w_last;
    logic [AW-1:0] w_i;
    logic [AW-1:0] w_o;
    logic [WW-1:0] w_widx;

    // Outputs are registered, so an issue is launched on the edge before its cycle:
    // the edge ending the last clear, or any RUN edge until the final triple is out.
    assign w_start  = (r_state == S_IDLE || r_state == S_DONE) && go;
    assign w_launch = (r_state == S_CLEAR && clr_addr == AW'(N_OUT - 1)) ||
                      (r_state == S_RUN && !r_last_issued);
    assign w_en     = w_launch && !stall;

    issue_counter #(.N_IN(N_IN), .N_OUT(N_OUT)) u_cnt (
        .clk     (clk),
        .rst_n   (reset),
        .i_en    (w_en),
        .i_clear (w_start),
        .o_i     (w_i),
        .o_o     (w_o),
        .o_widx  (w_widx),
        .o_last  (w_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_drain       <= '0;
            r_last_issued <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            mac_start     <= 1'b0;
            clr_we        <= 1'b0;
            rf_sel        <= 1'b0;
            mac_addr      <= IDLE_ADDR;
            in_rd_addr    <= '0;
            wt_rd_addr    <= '0;
            clr_addr      <= '0;
        end else begin
            done      <= 1'b0;
            mac_start <= w_en && w_widx == '0;
            mac_addr  <= w_en ? w_o : IDLE_ADDR;
            if (w_en) begin
                in_rd_addr <= w_i;
                wt_rd_addr <= w_widx;
            end
            if (w_start)
                r_last_issued <= 1'b0;
            else if (w_en && w_last)
                r_last_issued <= 1'b1;
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_state  <= w_start ? S_CLEAR : S_IDLE;
                    busy     <= w_start;
                    rf_sel   <= w_start;
                    clr_we   <= w_start;
                    clr_addr <= '0;
                end
                S_CLEAR: begin
                    if (clr_addr == AW'(N_OUT - 1)) begin
                        r_state <= S_RUN;
                        clr_we  <= 1'b0;
                        rf_sel  <= 1'b0;
                    end else begin
                        clr_addr <= clr_addr + AW'(1);
                    end
                end
                S_RUN: begin
                    if (r_last_issued) begin
                        r_state <= S_DRAIN;
                        r_drain <= '0;
                    end
                end
                S_DRAIN: begin
                    if (r_drain == 8'(PIPE_DEPTH - 1)) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        r_drain <= r_drain + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_layer_sched.sv
// tb_layer_sched: directed self-checking bench for layer_sched (default 16x10 and 1x1 layers)
// with a behavioural register-file/MAC model accumulating psums from the issued triples.
module tb_layer_sched;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        go = 1'b0;
    logic        stall = 1'b0;
    logic        go_b = 1'b0;
    logic        busy, done, mac_start, clr_we, rf_sel;
    logic [6:0]  in_rd_addr, mac_addr, clr_addr;
    logic [13:0] wt_rd_addr;
    logic        busy_b, done_b, mac_start_b, clr_we_b, rf_sel_b;
    logic [6:0]  in_rd_addr_b, mac_addr_b, clr_addr_b;
    logic [13:0] wt_rd_addr_b;

    int checks = 0, errors = 0, cyc = 0, base = 0, rel_m = 0;
    int n_clr, clr_first, clr_last, clr_bad, n_iss, iss_first, iss_last, iss_bad;
    int start_bad, n_done, done_cyc;
    int psum [100];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    layer_sched dut (
        .clk(clk), .reset(reset), .go(go), .stall(stall), .busy(busy), .done(done),
        .in_rd_addr(in_rd_addr), .wt_rd_addr(wt_rd_addr), .mac_addr(mac_addr),
        .mac_start(mac_start), .clr_we(clr_we), .clr_addr(clr_addr), .rf_sel(rf_sel)
    );

    layer_sched #(.N_IN(1), .N_OUT(1)) dut_b (
        .clk(clk), .reset(reset), .go(go_b), .stall(1'b0), .busy(busy_b), .done(done_b),
        .in_rd_addr(in_rd_addr_b), .wt_rd_addr(wt_rd_addr_b), .mac_addr(mac_addr_b),
        .mac_start(mac_start_b), .clr_we(clr_we_b), .clr_addr(clr_addr_b), .rf_sel(rf_sel_b)
    );

    function automatic int wval(int k);
        return k % 7 - 3;
    endfunction

    function automatic int exp_psum(int o);
        int s = 0;
        for (int i = 0; i < 16; i++) s += (i + 1) * wval(o * 16 + i);
        return s;
    endfunction

    // Register-file/MAC model and issue-sequence observer for the default instance.
    always @(negedge clk) begin
        rel_m = cyc - base;
        if (clr_we) begin
            if (n_clr == 0) clr_first = rel_m;
            clr_last = rel_m;
            if (clr_addr != 7'(n_clr) || !rf_sel) clr_bad++;
            n_clr++;
            if (clr_addr < 7'd100) psum[clr_addr] = 0;
        end
        if (mac_addr != 7'd127) begin
            if (n_iss == 0) iss_first = rel_m;
            iss_last = rel_m;
            if (mac_addr != 7'(n_iss / 16) || in_rd_addr != 7'(n_iss % 16) ||
                wt_rd_addr != 14'(n_iss) || rf_sel || !busy) iss_bad++;
            if (mac_start != (n_iss == 0)) start_bad++;
            if (mac_addr < 7'd100)
                psum[mac_addr] += (int'(in_rd_addr) + 1) * wval(int'(wt_rd_addr));
            n_iss++;
        end else if (mac_start) begin
            start_bad++;
        end
        if (done) begin
            n_done++;
            done_cyc = rel_m;
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr_stats();
        n_clr = 0; clr_first = 0; clr_last = 0; clr_bad = 0;
        n_iss = 0; iss_first = 0; iss_last = 0; iss_bad = 0;
        start_bad = 0; n_done = 0; done_cyc = 0;
    endtask

    task automatic start_go();
        @(negedge clk);
        base = cyc;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_rel(input int r);
        for (int k = 0; k < 500 && (cyc - base) < r; k++) @(negedge clk);
        chk("reach_cycle", cyc - base, r);
    endtask

    task automatic wait_done();
        for (int k = 0; k < 400 && n_done == 0; k++) @(negedge clk);
        chk("done_seen", n_done, 1);
    endtask

    task automatic chk_psums(input string tag);
        int bad = 0;
        for (int o = 0; o < 10; o++) if (psum[o] != exp_psum(o)) bad++;
        chk(tag, bad, 0);
    endtask

    initial begin
        for (int k = 0; k < 100; k++) psum[k] = 999;
        clr_stats();
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mac_start", mac_start, 0);
        chk("rst_clr_we", clr_we, 0);
        chk("rst_rf_sel", rf_sel, 0);
        chk("rst_mac_addr", mac_addr, 127);
        chk("rst_in_addr", in_rd_addr, 0);
        chk("rst_wt_addr", wt_rd_addr, 0);
        chk("rst_clr_addr", clr_addr, 0);
        reset = 1'b1;

        // Full layer, no stall
        clr_stats();
        start_go();
        wait_done();
        chk("clr_count", n_clr, 10);
        chk("clr_first", clr_first, 1);
        chk("clr_last", clr_last, 10);
        chk("clr_seq", clr_bad, 0);
        chk("iss_count", n_iss, 160);
        chk("iss_first", iss_first, 11);
        chk("iss_last", iss_last, 170);
        chk("iss_seq", iss_bad, 0);
        chk("start_once", start_bad, 0);
        chk("done_cycle", done_cyc, 177);
        for (int o = 0; o < 10; o++) chk($sformatf("psum%0d", o), psum[o], exp_psum(o));
        wait_rel(178);
        chk("done_pulse", done, 0);
        chk("idle_busy", busy, 0);

        // Four-cycle stall at (3,5)
        clr_stats();
        start_go();
        wait_rel(63);
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("stall_bubble", mac_addr, 127);
            chk("stall_in_hold", in_rd_addr, 4);
            chk("stall_wt_hold", wt_rd_addr, 52);
        end
        stall = 1'b0;
        @(negedge clk);
        chk("resume_o", mac_addr, 3);
        chk("resume_i", in_rd_addr, 5);
        chk("resume_wt", wt_rd_addr, 53);
        wait_done();
        chk("stall_done_cycle", done_cyc, 181);
        chk("stall_iss_count", n_iss, 160);
        chk("stall_iss_seq", iss_bad, 0);
        chk_psums("stall_psums");

        // Stall on the first RUN cycle
        clr_stats();
        start_go();
        wait_rel(10);
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("first_bubble", mac_addr, 127);
            chk("first_no_start", mac_start, 0);
        end
        stall = 1'b0;
        @(negedge clk);
        chk("first_start", mac_start, 1);
        chk("first_o", mac_addr, 0);
        chk("first_wt", wt_rd_addr, 0);
        wait_done();
        chk("first_start_seq", start_bad, 0);
        chk("first_done_cycle", done_cyc, 179);

        // Asynchronous reset mid-RUN, then a clean rerun
        clr_stats();
        start_go();
        wait_rel(50);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_mac_addr", mac_addr, 127);
        chk("arst_in", in_rd_addr, 0);
        chk("arst_wt", wt_rd_addr, 0);
        chk("arst_rf_sel", rf_sel, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        chk("arst_no_done", n_done, 0);
        clr_stats();
        start_go();
        wait_done();
        chk("rerun_clr", n_clr, 10);
        chk("rerun_iss", n_iss, 160);
        chk("rerun_seq", iss_bad, 0);
        chk("rerun_done_cycle", done_cyc, 177);
        chk_psums("rerun_psums");

        // go pulses during RUN and DRAIN are ignored
        clr_stats();
        start_go();
        wait_rel(100);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        wait_rel(172);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        wait_done();
        chk("go_ign_clr", n_clr, 10);
        chk("go_ign_iss", n_iss, 160);
        chk("go_ign_done_cycle", done_cyc, 177);
        wait_rel(180);
        chk("go_ign_idle", busy, 0);

        // 1x1 layer with go held high
        @(negedge clk);
        base = cyc;
        go_b = 1'b1;
        @(negedge clk);
        chk("b_clr_we", clr_we_b, 1);
        chk("b_clr_addr", clr_addr_b, 0);
        chk("b_rf_sel", rf_sel_b, 1);
        @(negedge clk);
        chk("b_issue_o", mac_addr_b, 0);
        chk("b_issue_start", mac_start_b, 1);
        chk("b_issue_clr_we", clr_we_b, 0);
        chk("b_issue_wt", wt_rd_addr_b, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("b_drain_bubble", mac_addr_b, 127);
            chk("b_drain_busy", busy_b, 1);
            chk("b_drain_nodone", done_b, 0);
        end
        @(negedge clk);
        chk("b_done_cycle", cyc - base, 9);
        chk("b_done", done_b, 1);
        chk("b_done_busy", busy_b, 0);
        @(negedge clk);
        chk("b_reclear", clr_we_b, 1);
        chk("b_rebusy", busy_b, 1);
        go_b = 1'b0;
        for (int k = 0; k < 20 && !done_b; k++) @(negedge clk);
        chk("b_redone", done_b, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/layer_sched.md
# layer_sched

Sequencing controller for the `mac2` pipelined multiply-accumulate unit. It zeroes the partial-sum entries in the register file, then issues every (input, weight, output-address) triple of one fully connected layer into the MAC. It inserts bubbles when the register file is stalled, drains the 6-stage pipeline, and signals completion. It sits between the top-level control, the input/weight buffers (asynchronous read) and the MAC/register-file pair, and owns the register-file port mux select.

## Interface
- `N_IN`, 16: inputs per output neuron; 1..100.
- `N_OUT`, 10: output neurons (psum addresses 0..N_OUT-1); 1..100.
- `PIPE_DEPTH`, 6: MAC latency from `addr_in` to writeback.
- `IDLE_ADDR`, 7'd127: bubble address; outside 0..99, so the MAC disables read/write.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; `reset`=0 forces the reset state immediately.
- `go` in 1: start-of-layer request, sampled in IDLE only.
- `stall` in 1: register file busy with another master; no issue this cycle.
- `busy` out 1: high in CLEAR/RUN/DRAIN.
- `done` out 1: one-cycle completion pulse.
- `in_rd_addr` out 7: input-buffer read address.
- `wt_rd_addr` out 14: weight-buffer read address, o*N_IN+i.
- `mac_addr` out 7: drives MAC `addr_in`.
- `mac_start` out 1: drives MAC `start`; high on the first issued triple of a layer.
- `clr_we` out 1: scheduler write-enable to the register file (writes 16'sd0).
- `clr_addr` out 7: clear address.
- `rf_sel` out 1: 1 = scheduler owns the register-file write port, 0 = MAC.

## Operation
- Reset values:
  - `busy`=0, `done`=0, `mac_start`=0, `clr_we`=0, `rf_sel`=0.
  - `mac_addr`=IDLE_ADDR.
  - `in_rd_addr`, `wt_rd_addr`, `clr_addr` = 0.
  - State IDLE.
- States:
  - IDLE: `go`=1 → CLEAR.
  - CLEAR: `rf_sel`=1, `clr_we`=1, `clr_addr` counts 0..N_OUT-1, one per cycle. `stall` is ignored, because the scheduler owns the port. After the last address → RUN.
  - RUN: nested counter, o outer 0..N_OUT-1 and i inner 0..N_IN-1.
    - Each non-stalled cycle drives `in_rd_addr`=i, `wt_rd_addr`=o*N_IN+i, `mac_addr`=o, then advances the counter.
    - A stalled cycle drives `mac_addr`=IDLE_ADDR and holds the counter and the address outputs.
    - After the issue of (N_OUT-1, N_IN-1) → DRAIN.
  - DRAIN: `mac_addr`=IDLE_ADDR for exactly PIPE_DEPTH cycles; `stall` is ignored (bubbles only) → DONE.
  - DONE: `done`=1 and `busy`=0 for one cycle → IDLE.
- `mac_start` is high only on the cycle issuing (0,0). If that cycle is stalled, `mac_start` moves to the first non-stalled issue.
- `go` outside IDLE is ignored; `go` held high re-triggers on the cycle after DONE.
- All outputs are registered. Buffer read addresses and `mac_addr` change on the same edge, so asynchronous-read data aligns with `addr_in`.
- `wt_rd_addr` is computed by an incrementing counter, not a multiplier. It resets to 0 at the start of RUN and increments on every non-stalled issue.
- Reset during any state aborts the layer, with no `done`. The register-file contents are left as-is.

## Timing
- `go` sampled at edge 0, no stalls:
  - `clr_we` high cycles 1..N_OUT.
  - Issues in cycles N_OUT+1..N_OUT+N_IN*N_OUT.
  - Drain occupies the next PIPE_DEPTH cycles.
  - `done` in cycle N_OUT+N_IN*N_OUT+PIPE_DEPTH+1.
  - Defaults: clear 1-10, issue 11-170, drain 171-176, `done` 177.
- Each stalled RUN cycle adds exactly one cycle.
- The last MAC writeback occurs in the final DRAIN cycle, before `done`.
- Consecutive issues to the same o are legal, because the MAC reads and writes a psum in the same stage-6 cycle.

## Structure
- Package `layer_pkg`:
  - state enum (IDLE, CLEAR, RUN, DRAIN, DONE);
  - IDLE_ADDR;
  - MAC_PIPE_DEPTH=6;
  - address widths.
- Sub-module `issue_counter`: nested i/o counter with `en` (=RUN & !stall), `clear`, and `last` flag. It also produces the linear weight index.
- The FSM, output registers and clear counter live in `layer_sched`.

## Test plan
- Defaults, `go` pulse, no stall:
  - `clr_we` for 10 cycles at addresses 0..9.
  - 160 issues, with `mac_addr` stepping 0 (×16) … 9 (×16) and `wt_rd_addr` 0..159.
  - `done` at cycle 177; with a MAC/regfile model, psum[o]=Σ in[i]*w[o*16+i].
- `stall`=1 on RUN cycles issuing (3,5) for 4 cycles:
  - `mac_addr`=127 and addresses held during the stall.
  - `done` at cycle 181; psums unchanged versus the no-stall run.
- `stall`=1 during the first RUN cycle: `mac_start` asserted with the first real issue (0,0), never on a bubble.
- `reset`=0 asynchronously mid-RUN (cycle 50):
  - outputs return to reset values without a clock edge; no `done`;
  - a subsequent `go` repeats the full sequence from CLEAR.
- N_IN=1, N_OUT=1: clear 1 cycle, 1 issue, `done` at cycle 9. `go` held high re-enters CLEAR at cycle 10.
- `go` pulsed during RUN and DRAIN: no effect on sequence or timing.
